adc_pkt_framer: RTL and testbench

Packs the preprocessing stage's 14-bit output samples into 32-bit AXI-Stream words (two samples per word) and frames them into fixed-length packets with `tlast` for the downstream DMA. It sits directly after the preprocessing stage in the ADC clock domain (260 MHz, one sample every `CLOCKS_PER_SAMPLE` = 3 cycles nominal). A small internal FIFO absorbs `tready` back-pressure. Words that cannot be stored are dropped and counted.

---
 rtl/adc_pkt_pkg.sv | 21 ++
 rtl/adc_pkt_framer_if.sv | 14 +
 rtl/pkt_sync_fifo.sv | 76 +++++++
 rtl/adc_pkt_framer.sv | 165 ++++++++++++++++
 tb/tb_adc_pkt_framer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC packet framer: widths, FSM states
// and the {tlast, tdata} entry stored in the output FIFO.
package adc_pkt_pkg;

  localparam int SAMPLE_WIDTH = 14;
  localparam int AXIS_WIDTH   = 32;
  localparam int HALF_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } framer_state_t;

  typedef struct packed {
    logic                  tlast;
    logic [AXIS_WIDTH-1:0] tdata;
  } fifo_entry_t;

endpackage

// File: rtl/adc_pkt_framer_if.sv
// AXI-Stream output bundle of the framer towards the DMA.
// Handshake: a word moves on a rising edge where tvalid & tready are both 1;
// tvalid never waits on tready, and tdata/tlast hold while tvalid & !tready.
interface adc_pkt_framer_if;
  import adc_pkt_pkg::*;

  logic [AXIS_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pkt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head entry.
// Capacity is DEPTH entries counting the head; a write at full is accepted
// when the head is read in the same cycle.
module pkt_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_accept_o,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;
  logic [AW:0]      total;
  logic             rd_fire;
  logic             load;

  always_comb begin
    total       = mem_cnt_q + {{AW{1'b0}}, head_vld_q};
    full_o      = (total == (AW+1)'(DEPTH));
    empty_o     = (total == '0);
    rd_fire     = head_vld_q & rd_en_i;
    wr_accept_o = wr_en_i & (~full_o | rd_fire);
    // Writes always land in the array; the head refills from it one edge later.
    load        = (mem_cnt_q != '0) & (~head_vld_q | rd_fire);

    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (rd_fire) head_vld_d = 1'b0;
    if (load) begin
      head_d     = mem_q[rptr_q];
      head_vld_d = 1'b1;
    end
    rptr_d    = rptr_q + AW'(load);
    wptr_d    = wptr_q + AW'(wr_accept_o);
    mem_cnt_d = mem_cnt_q + (AW+1)'(wr_accept_o) - (AW+1)'(load);
  end

  always_ff @(posedge clk) begin
    if (wr_accept_o) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = head_vld_q;

endmodule

// File: rtl/adc_pkt_framer.sv
// Packs pairs of signed ADC samples into 32-bit words, frames them into
// PKT_WORDS-word packets with tlast and buffers them for the DMA stream.
module adc_pkt_framer
  import adc_pkt_pkg::*;
#(
  parameter int SAMPLE_WIDTH = adc_pkt_pkg::SAMPLE_WIDTH,
  parameter int PKT_WORDS    = 256,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [15:0]             num_pkts_i,
  input  logic [SAMPLE_WIDTH-1:0] s_data_i,
  input  logic                    s_valid_i,
  adc_pkt_framer_if.master        m_axis,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             ovf_cnt_o,
  output framer_state_t           state_o
);

  localparam int WCW = $clog2(PKT_WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);

  framer_state_t   state_q, state_d;
  logic [15:0]     num_pkts_q, num_pkts_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic            phase_q, phase_d;
  logic [HALF_WIDTH-1:0] low_q, low_d;
  logic            pend_q, pend_d;
  fifo_entry_t     pend_entry_q, pend_entry_d;
  logic [15:0]     ovf_cnt_q, ovf_cnt_d;

  logic [HALF_WIDTH-1:0] sample_ext;
  logic            fifo_wr_en;
  logic            fifo_wr_acc;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_vld;
  fifo_entry_t     fifo_head;

  assign sample_ext = {{(HALF_WIDTH-SAMPLE_WIDTH){s_data_i[SAMPLE_WIDTH-1]}}, s_data_i};

  always_comb begin
    state_d      = state_q;
    num_pkts_d   = num_pkts_q;
    pkt_cnt_d    = pkt_cnt_q;
    word_cnt_d   = word_cnt_q;
    phase_d      = phase_q;
    low_d        = low_q;
    pend_d       = pend_q;
    pend_entry_d = pend_entry_q;
    ovf_cnt_d    = ovf_cnt_q;
    fifo_wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = RUN;
          num_pkts_d = num_pkts_i;
          pkt_cnt_d  = '0;
          word_cnt_d = '0;
          ovf_cnt_d  = '0;
          phase_d    = 1'b0;
          pend_d     = 1'b0;
        end
      end

      RUN: begin
        // A completed pair waits one cycle in pend_* before it tries the FIFO.
        pend_d     = 1'b0;
        fifo_wr_en = pend_q;
        if (pend_q) begin
          if (fifo_wr_acc) begin
            if (pend_entry_q.tlast) begin
              word_cnt_d = '0;
              pkt_cnt_d  = pkt_cnt_q + 16'd1;
              if (((num_pkts_q != 16'd0) && (pkt_cnt_d == num_pkts_q)) || !enable_i)
                state_d = DRAIN;
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
            end
          end else if (fifo_full && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
          end
        end

        if (!enable_i && !pend_q && (word_cnt_q == '0) && !phase_q) begin
          state_d = DRAIN;
        end else if (s_valid_i && (state_d == RUN)) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            low_d = sample_ext;
          end else begin
            pend_d             = 1'b1;
            pend_entry_d.tlast = (word_cnt_d == LAST_WORD);
            pend_entry_d.tdata = {sample_ext, low_q};
          end
        end
      end

      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_pkts_q   <= '0;
      pkt_cnt_q    <= '0;
      word_cnt_q   <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
      pend_q       <= 1'b0;
      pend_entry_q <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      num_pkts_q   <= num_pkts_d;
      pkt_cnt_q    <= pkt_cnt_d;
      word_cnt_q   <= word_cnt_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      pend_q       <= pend_d;
      pend_entry_q <= pend_entry_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  pkt_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (fifo_wr_en),
    .wr_data_i   (pend_entry_q),
    .wr_accept_o (fifo_wr_acc),
    .full_o      (fifo_full),
    .rd_en_i     (m_axis.tready),
    .rd_data_o   (fifo_head),
    .rd_valid_o  (fifo_vld),
    .empty_o     (fifo_empty)
  );

  assign m_axis.tdata  = fifo_head.tdata;
  assign m_axis.tlast  = fifo_head.tlast;
  assign m_axis.tvalid = fifo_vld;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign ovf_cnt_o = ovf_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_adc_pkt_framer.sv
// Bench for adc_pkt_framer with PKT_WORDS=4, FIFO_DEPTH=16: table-driven packing
// vectors, overflow, stop-at-boundary, async reset and random back-pressure.
module tb_adc_pkt_framer;
  import adc_pkt_pkg::*;

  localparam int PW = 4;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   num_pkts = 16'd0;
  logic [13:0]   s_data = 14'd0;
  logic          s_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   ovf;
  framer_state_t dbg_state;

  adc_pkt_framer_if axis ();

  always #5 clk = ~clk;

  adc_pkt_framer #(
    .SAMPLE_WIDTH (14),
    .PKT_WORDS    (PW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .num_pkts_i (num_pkts),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .m_axis     (axis),
    .busy_o     (busy),
    .done_o     (done),
    .ovf_cnt_o  (ovf),
    .state_o    (dbg_state)
  );

  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    logic [32:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [32:0] exp_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          model_idx = 0;
  int          store_budget = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: runs at the falling edge, ahead of the edge that transfers.
  task automatic monitor();
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 33'(axis.tvalid), 33'd1);
        chk("stall_word", {axis.tlast, axis.tdata}, prev_word);
      end
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", {axis.tlast, axis.tdata});
        end else begin
          chk("word", {axis.tlast, axis.tdata}, exp_q.pop_front());
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_word  = {axis.tlast, axis.tdata};
      if (done) done_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_ready) axis.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_ready(input logic v);
    axis.tready = v;
  endtask

  function automatic logic [31:0] pack(input logic [13:0] a, input logic [13:0] b);
    return {{2{b[13]}}, b, {2{a[13]}}, a};
  endfunction

  task automatic drive_sample(input logic [13:0] s);
    s_data  = s;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    if (store_budget > 0) begin
      exp_q.push_back({((model_idx % PW) == PW - 1), w});
      model_idx++;
      store_budget--;
    end
  endtask

  task automatic send_pair(input logic [13:0] a, input logic [13:0] b);
    push_word(pack(a, b));
    drive_sample(a);
    drive_sample(b);
  endtask

  task automatic start_run(input logic [15:0] n);
    num_pkts  = n;
    enable    = 1'b1;
    model_idx = 0;
    done_cnt  = 0;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    tick();
    tick();
    chk("done_pulses", 33'(done_cnt), 33'd1);
    chk("busy_after_done", 33'(busy), 33'd0);
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("queue_drained", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a: 14'h0001, b: 14'h3FFF, exp: {1'b0, 32'hFFFF_0001}};
    tbl[1] = '{a: 14'h0002, b: 14'h3FFE, exp: {1'b0, 32'hFFFE_0002}};
    tbl[2] = '{a: 14'h0003, b: 14'h3FFD, exp: {1'b0, 32'hFFFD_0003}};
    tbl[3] = '{a: 14'h0004, b: 14'h3FFC, exp: {1'b1, 32'hFFFC_0004}};
    tbl[4] = '{a: 14'h1FFF, b: 14'h2000, exp: {1'b0, 32'hE000_1FFF}};
    tbl[5] = '{a: 14'h2000, b: 14'h1FFF, exp: {1'b0, 32'h1FFF_E000}};
    tbl[6] = '{a: 14'h0000, b: 14'h3FFF, exp: {1'b0, 32'hFFFF_0000}};
    tbl[7] = '{a: 14'h1234, b: 14'h0ABC, exp: {1'b1, 32'h0ABC_1234}};

    axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 33'(axis.tvalid), 33'd0);
    chk("rst_tlast", 33'(axis.tlast), 33'd0);
    chk("rst_tdata", 33'(axis.tdata), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_done", 33'(done), 33'd0);
    chk("rst_ovf", 33'(ovf), 33'd0);
    chk("rst_state", 33'(dbg_state), 33'(IDLE));
    rst_n = 1'b1;
    tick();

    // Two 4-word packets from the vector table, with latency check on word 1.
    set_ready(1'b1);
    store_budget = 0;
    start_run(16'd2);
    chk("run_busy", 33'(busy), 33'd1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i].exp);
      drive_sample(tbl[i].a);
      if (i == 0) begin
        s_data  = tbl[i].b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("lat_t0_tvalid", 33'(axis.tvalid), 33'd0);
        tick();
        chk("lat_t1_tvalid", 33'(axis.tvalid), 33'd0);
        tick();
        chk("lat_t2_tvalid", 33'(axis.tvalid), 33'd1);
        chk("lat_t2_tdata", 33'(axis.tdata), 33'h0_FFFF_0001);
      end else begin
        drive_sample(tbl[i].b);
      end
    end
    enable = 1'b0;
    wait_done(100);
    chk("t1_queue_empty", 33'(exp_q.size()), 33'd0);
    chk("t1_ovf", 33'(ovf), 33'd0);

    // Back-pressure: 20 words offered, 16 stored, 4 dropped.
    set_ready(1'b0);
    store_budget = 16;
    start_run(16'd0);
    for (int i = 0; i < 20; i++) send_pair(14'(2 * i + 5), 14'(16383 - 3 * i));
    repeat (3) tick();
    chk("ovf_count", 33'(ovf), 33'd4);
    chk("ovf_tvalid_held", 33'(axis.tvalid), 33'd1);
    set_ready(1'b1);
    wait_empty(100);
    enable = 1'b0;
    wait_done(100);
    chk("ovf_after_run", 33'(ovf), 33'd4);

    // Continuous mode, enable drops at word 2 of packet 3.
    store_budget = 1000;
    start_run(16'd0);
    for (int i = 0; i < 14; i++) begin
      if (i == 12) store_budget = 0;
      send_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
      if (i == 9) enable = 1'b0;
    end
    wait_done(100);
    repeat (10) tick();
    chk("stop_queue_empty", 33'(exp_q.size()), 33'd0);
    chk("stop_no_tvalid", 33'(axis.tvalid), 33'd0);
    chk("stop_idle", 33'(dbg_state), 33'(IDLE));

    // Asynchronous reset with 5 words queued and half a pair packed.
    set_ready(1'b0);
    store_budget = 1000;
    start_run(16'd0);
    for (int i = 0; i < 5; i++) send_pair(14'(100 + i), 14'(200 + i));
    drive_sample(14'h0155);
    chk("pre_rst_tvalid", 33'(axis.tvalid), 33'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 33'(axis.tvalid), 33'd0);
    chk("arst_tlast", 33'(axis.tlast), 33'd0);
    chk("arst_tdata", 33'(axis.tdata), 33'd0);
    chk("arst_busy", 33'(busy), 33'd0);
    chk("arst_ovf", 33'(ovf), 33'd0);
    chk("arst_state", 33'(dbg_state), 33'(IDLE));
    exp_q.delete();
    enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    set_ready(1'b1);
    store_budget = 1000;
    start_run(16'd1);
    for (int i = 0; i < 4; i++) send_pair(14'(16000 - i), 14'(7 + i));
    enable = 1'b0;
    wait_done(100);
    chk("post_rst_queue_empty", 33'(exp_q.size()), 33'd0);

    // Ten packets under random tready.
    rand_ready = 1'b1;
    store_budget = 1000;
    start_run(16'd10);
    for (int i = 0; i < 40; i++)
      send_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
    enable = 1'b0;
    wait_done(300);
    rand_ready = 1'b0;
    set_ready(1'b1);
    chk("rand_queue_empty", 33'(exp_q.size()), 33'd0);
    chk("rand_ovf", 33'(ovf), 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
